// File: rtl/ysyx_22040759_exe_mdu_if.sv
// Handshake and data bundle between decode, the MDU execute stage and memory stage.
`timescale 1ns/1ps
interface ysyx_22040759_exe_mdu_if #(
    parameter int XLEN   = 64,
    parameter int NFWD   = 2,
    parameter int FSEL_W = $clog2(NFWD + 1)
);
    logic                 ds_to_es_valid;
    logic                 es_allowin;
    logic [2:0]           ds_op;
    logic                 ds_word;
    logic [4:0]           ds_rd;
    logic [XLEN-1:0]      ds_src1;
    logic [XLEN-1:0]      ds_src2;
    logic [FSEL_W-1:0]    fwd_sel_a;
    logic [FSEL_W-1:0]    fwd_sel_b;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 flush;
    logic                 ms_allowin;
    logic                 es_to_ms_valid;
    logic [XLEN-1:0]      es_result;
    logic [4:0]           es_rd;
    logic                 es_busy;

    modport master (
        output ds_to_es_valid, ds_op, ds_word, ds_rd, ds_src1, ds_src2,
               fwd_sel_a, fwd_sel_b, fwd_data, flush, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_result, es_rd, es_busy
    );

    modport slave (
        input  ds_to_es_valid, ds_op, ds_word, ds_rd, ds_src1, ds_src2,
               fwd_sel_a, fwd_sel_b, fwd_data, flush, ms_allowin,
        output es_allowin, es_to_ms_valid, es_result, es_rd, es_busy
    );
endinterface

// File: rtl/ysyx_22040759_exe_mdu.sv
// Iterative MDU execute stage: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Define YSYX_22040759_MDU_WORD_EN (XLEN=64 only) to add the 32-bit W-variant datapath.
`timescale 1ns/1ps
module ysyx_22040759_exe_mdu #(
    parameter int XLEN   = 64,
    parameter int NFWD   = 2,
    parameter int FSEL_W = $clog2(NFWD + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_22040759_exe_mdu_if.slave io
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt, last, last_init;
    logic [XLEN-1:0]   hi, lo, dvs, res_q;
    logic [4:0]        rd_q;
    logic [2:0]        op_q;
    logic              neg_q, neg_r;
`ifdef YSYX_22040759_MDU_WORD_EN
    logic              word_q;
`endif

    logic              accept, sgn_a, sgn_b, neg_a, neg_b, is_div, skip;
    logic [XLEN-1:0]   opa, opb, a_ext, b_ext, abs_a, abs_b, min_neg, skip_res, lo_init;
    logic [XLEN:0]     mul_sum, div_sh;
    logic [XLEN+1:0]   div_dif;
    logic [XLEN-1:0]   nhi, nlo, quo, rem, raw, fin;
    logic [2*XLEN-1:0] prod;

    assign io.es_allowin     = (state == IDLE) || (state == DONE && io.ms_allowin);
    assign accept            = io.ds_to_es_valid && io.es_allowin && !io.flush;
    assign io.es_to_ms_valid = (state == DONE);
    assign io.es_busy        = (state == BUSY);
    assign io.es_result      = res_q;
    assign io.es_rd          = rd_q;

    // Select values past NFWD fall through to the register operand.
    always_comb begin
        opa = io.ds_src1;
        opb = io.ds_src2;
        for (int k = 0; k < NFWD; k++) begin
            if (int'(io.fwd_sel_a) == k + 1) opa = io.fwd_data[k*XLEN +: XLEN];
            if (int'(io.fwd_sel_b) == k + 1) opb = io.fwd_data[k*XLEN +: XLEN];
        end
    end

    always_comb begin
        is_div    = io.ds_op[2];
        sgn_a     = !(io.ds_op == 3'd3 || io.ds_op == 3'd5 || io.ds_op == 3'd7);
        sgn_b     = sgn_a && (io.ds_op != 3'd2);
        a_ext     = opa;
        b_ext     = opb;
        min_neg   = {1'b1, {(XLEN-1){1'b0}}};
        last_init = CW'(XLEN - 1);
`ifdef YSYX_22040759_MDU_WORD_EN
        if (io.ds_word) begin
            a_ext     = sgn_a ? {{32{opa[31]}}, opa[31:0]} : {32'b0, opa[31:0]};
            b_ext     = sgn_b ? {{32{opb[31]}}, opb[31:0]} : {32'b0, opb[31:0]};
            min_neg   = {{33{1'b1}}, 31'b0};
            last_init = CW'(31);
        end
`endif
        neg_a   = sgn_a && a_ext[XLEN-1];
        neg_b   = sgn_b && b_ext[XLEN-1];
        abs_a   = neg_a ? -a_ext : a_ext;
        abs_b   = neg_b ? -b_ext : b_ext;
        lo_init = is_div ? abs_a : abs_b;
`ifdef YSYX_22040759_MDU_WORD_EN
        // Word divide left-aligns the dividend so 32 shifts consume all of it.
        if (io.ds_word && is_div) lo_init = abs_a << 32;
`endif
        skip = is_div && (b_ext == '0 || (sgn_a && a_ext == min_neg && b_ext == '1));
        if (io.ds_op[1]) skip_res = (b_ext == '0) ? a_ext : '0;
        else             skip_res = (b_ext == '0) ? '1 : a_ext;
`ifdef YSYX_22040759_MDU_WORD_EN
        if (io.ds_word) skip_res = {{32{skip_res[31]}}, skip_res[31:0]};
`endif
    end

    // hi/lo double as {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        div_sh  = {hi, lo[XLEN-1]};
        div_dif = {1'b0, div_sh} - {2'b0, dvs};
        if (op_q[2]) begin
            nhi = div_dif[XLEN+1] ? div_sh[XLEN-1:0] : div_dif[XLEN-1:0];
            nlo = {lo[XLEN-2:0], !div_dif[XLEN+1]};
        end else begin
            nhi = mul_sum[XLEN:1];
            nlo = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod = {nhi, nlo};
        quo  = nlo;
`ifdef YSYX_22040759_MDU_WORD_EN
        if (word_q) begin
            prod = {{XLEN{1'b0}}, nhi[31:0], nlo[63:32]};
            quo  = {32'b0, nlo[31:0]};
        end
`endif
        rem = nhi;
        if (neg_q) begin
            prod = -prod;
            quo  = -quo;
        end
        if (neg_r) rem = -rem;
        if (op_q[2])              raw = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 0)  raw = prod[XLEN-1:0];
        else                      raw = prod[2*XLEN-1:XLEN];
        fin = raw;
`ifdef YSYX_22040759_MDU_WORD_EN
        if (word_q) begin
            if (!op_q[2] && op_q[1:0] != 0) fin = {{32{prod[63]}}, prod[63:32]};
            else                            fin = {{32{raw[31]}}, raw[31:0]};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= '0;
            hi    <= '0;
            lo    <= '0;
            dvs   <= '0;
            res_q <= '0;
            rd_q  <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`ifdef YSYX_22040759_MDU_WORD_EN
            word_q <= 1'b0;
`endif
        end else if (io.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            state <= skip ? DONE : BUSY;
            cnt   <= '0;
            last  <= last_init;
            hi    <= '0;
            lo    <= lo_init;
            dvs   <= is_div ? abs_b : abs_a;
            rd_q  <= io.ds_rd;
            op_q  <= io.ds_op;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            if (skip) res_q <= skip_res;
`ifdef YSYX_22040759_MDU_WORD_EN
            word_q <= io.ds_word;
`endif
        end else begin
            case (state)
                BUSY: begin
                    hi  <= nhi;
                    lo  <= nlo;
                    cnt <= cnt + 1'b1;
                    if (cnt == last) begin
                        state <= DONE;
                        res_q <= fin;
                    end
                end
                DONE:    if (io.ms_allowin) state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040759_exe_mdu.sv
// Self-checking bench for the MDU execute stage against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ysyx_22040759_exe_mdu;
    localparam logic [63:0] MN = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passed = 0;

    ysyx_22040759_exe_mdu_if #(.XLEN(64), .NFWD(2)) intf ();
    ysyx_22040759_exe_mdu #(.XLEN(64), .NFWD(2)) dut (.clk(clk), .rst(rst), .io(intf));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       sa, sb, ua, ub, p;
        logic signed [63:0] q;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'b0, a};
        ub = {64'b0, b};
        ref_mdu = '0;
        case (op)
            3'd0: ref_mdu = a * b;
            3'd1: begin p = sa * sb; ref_mdu = p[127:64]; end
            3'd2: begin p = sa * ub; ref_mdu = p[127:64]; end
            3'd3: begin p = ua * ub; ref_mdu = p[127:64]; end
            3'd4: begin
                if (b == 0) ref_mdu = '1;
                else if (a == MN && b == '1) ref_mdu = a;
                else begin q = $signed(a) / $signed(b); ref_mdu = q; end
            end
            3'd5: ref_mdu = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) ref_mdu = a;
                else if (a == MN && b == '1) ref_mdu = '0;
                else begin q = $signed(a) % $signed(b); ref_mdu = q; end
            end
            default: ref_mdu = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == MN && b == '1))) return 1;
        return 65;
    endfunction

    // Presents one op, releases valid after acceptance, returns the result and cycles until valid.
    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, output logic [63:0] res, output logic [4:0] rdo,
                         output int lat);
        @(negedge clk);
        intf.ds_to_es_valid = 1'b1;
        intf.ds_op   = op;
        intf.ds_src1 = a;
        intf.ds_src2 = b;
        intf.ds_rd   = rd;
        @(posedge clk); #1;
        intf.ds_to_es_valid = 1'b0;
        lat = 1;
        while (!intf.es_to_ms_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = intf.es_result;
        rdo = intf.es_rd;
        if (!intf.es_to_ms_valid) lat = -1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (intf.es_to_ms_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", intf.es_to_ms_valid); else passed++;
        checks++; if (intf.es_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", intf.es_busy); else passed++;
        checks++; if (intf.es_result !== 64'd0) $display("FAIL rst_result got %h want 0", intf.es_result); else passed++;
        checks++; if (intf.es_rd !== 5'd0) $display("FAIL rst_rd got %0d want 0", intf.es_rd); else passed++;
        checks++; if (intf.es_allowin !== 1'b1) $display("FAIL rst_allowin got %b want 1", intf.es_allowin); else passed++;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [7] = '{3'd0, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4};
        logic [63:0] as  [7] = '{64'd7, '1, -64'sd7, -64'sd7, 64'd5, 64'd5, MN};
        logic [63:0] bs  [7] = '{-64'sd3, 64'd2, 64'd2, 64'd2, 64'd0, 64'd0, '1};
        logic [63:0] ex  [7] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, MN};
        int          el  [7] = '{65, 65, 65, 65, 1, 1, 1};
        logic [63:0] res;
        logic [4:0]  rdo;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], as[i], bs[i], 5'(i + 1), res, rdo, lat);
            checks++; if (res !== ex[i]) $display("FAIL dir_result[%0d] got %h want %h", i, res, ex[i]); else passed++;
            checks++; if (lat !== el[i]) $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, el[i]); else passed++;
            checks++; if (rdo !== 5'(i + 1)) $display("FAIL dir_rd[%0d] got %0d want %0d", i, rdo, i + 1); else passed++;
        end
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return MN;
            3:       return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_random();
        logic [2:0]  op;
        logic [63:0] a, b, res, exp;
        logic [4:0]  rd, rdo;
        int          lat, elat;
        for (int i = 0; i < 30; i++) begin
            op   = 3'($urandom_range(0, 7));
            a    = pick_operand();
            b    = pick_operand();
            rd   = 5'($urandom);
            exp  = ref_mdu(op, a, b);
            elat = ref_lat(op, a, b);
            do_op(op, a, b, rd, res, rdo, lat);
            checks++; if (res !== exp || rdo !== rd || lat !== elat)
                $display("FAIL rand[%0d] op=%0d a=%h b=%h got %h/rd%0d/lat%0d want %h/rd%0d/lat%0d",
                         i, op, a, b, res, rdo, lat, exp, rd, elat);
            else passed++;
        end
    endtask

    task automatic test_forwarding();
        logic [63:0] res;
        logic [4:0]  rdo;
        int          lat;
        intf.fwd_data = {64'd9, 64'd100};
        intf.fwd_sel_a = 2'd2;
        do_op(3'd5, 64'd77, 64'd3, 5'd4, res, rdo, lat);
        checks++; if (res !== 64'd3) $display("FAIL fwd_slot1 got %h want 3", res); else passed++;
        intf.fwd_sel_a = 2'd0;
        intf.fwd_sel_b = 2'd1;
        do_op(3'd5, 64'd500, 64'd7, 5'd4, res, rdo, lat);
        checks++; if (res !== 64'd5) $display("FAIL fwd_slot0 got %h want 5", res); else passed++;
        intf.fwd_sel_a = 2'd3;
        intf.fwd_sel_b = 2'd0;
        do_op(3'd5, 64'd12, 64'd4, 5'd4, res, rdo, lat);
        checks++; if (res !== 64'd3) $display("FAIL fwd_out_of_range got %h want 3", res); else passed++;
        intf.fwd_sel_a = 2'd0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        @(negedge clk);
        intf.ds_to_es_valid = 1'b1;
        intf.ds_op = 3'd0; intf.ds_src1 = 64'd6; intf.ds_src2 = 64'd7; intf.ds_rd = 5'd9;
        @(posedge clk); #1;
        intf.ds_op = 3'd5; intf.ds_src1 = 64'd100; intf.ds_rd = 5'd3;
        while (!intf.es_to_ms_valid && n < 200) begin @(posedge clk); #1; n++; end
        intf.ms_allowin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (intf.es_to_ms_valid !== 1'b1 || intf.es_result !== 64'd42 || intf.es_rd !== 5'd9)
                $display("FAIL stall_hold[%0d] got v%b %h rd%0d want v1 %h rd9", i, intf.es_to_ms_valid, intf.es_result, intf.es_rd, 64'd42);
            else passed++;
            checks++; if (intf.es_allowin !== 1'b0) $display("FAIL stall_allowin[%0d] got %b want 0", i, intf.es_allowin); else passed++;
        end
        @(negedge clk);
        intf.ms_allowin = 1'b1;
        #1;
        checks++; if (intf.es_allowin !== 1'b1) $display("FAIL release_allowin got %b want 1", intf.es_allowin); else passed++;
        @(posedge clk); #1;
        intf.ds_to_es_valid = 1'b0;
        checks++; if (intf.es_busy !== 1'b1 || intf.es_to_ms_valid !== 1'b0)
            $display("FAIL b2b_busy got busy%b v%b want busy1 v0", intf.es_busy, intf.es_to_ms_valid); else passed++;
        n = 1;
        while (!intf.es_to_ms_valid && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (intf.es_result !== 64'd14 || intf.es_rd !== 5'd3 || n !== 65)
            $display("FAIL b2b_result got %h rd%0d lat%0d want %h rd3 lat65", intf.es_result, intf.es_rd, n, 64'd14);
        else passed++;
    endtask

    task automatic test_flush();
        int seen = 0;
        @(negedge clk);
        intf.ds_to_es_valid = 1'b1;
        intf.ds_op = 3'd4; intf.ds_src1 = 64'd1000; intf.ds_src2 = 64'd3; intf.ds_rd = 5'd11;
        @(posedge clk); #1;
        intf.ds_to_es_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk) intf.flush = 1'b1;
        @(posedge clk); #1;
        intf.flush = 1'b0;
        checks++; if (intf.es_busy !== 1'b0 || intf.es_to_ms_valid !== 1'b0 || intf.es_allowin !== 1'b1)
            $display("FAIL flush_busy got busy%b v%b allow%b want 0 0 1", intf.es_busy, intf.es_to_ms_valid, intf.es_allowin);
        else passed++;
        repeat (80) begin @(posedge clk); #1; if (intf.es_to_ms_valid) seen++; end
        checks++; if (seen !== 0) $display("FAIL flush_no_result got %0d valid cycles want 0", seen); else passed++;
        @(negedge clk);
        intf.ds_to_es_valid = 1'b1; intf.flush = 1'b1;
        @(posedge clk); #1;
        intf.ds_to_es_valid = 1'b0; intf.flush = 1'b0;
        checks++; if (intf.es_busy !== 1'b0 || intf.es_to_ms_valid !== 1'b0)
            $display("FAIL flush_blocks_accept got busy%b v%b want 0 0", intf.es_busy, intf.es_to_ms_valid); else passed++;
        @(negedge clk);
        intf.ds_to_es_valid = 1'b1; intf.ds_op = 3'd5; intf.ds_src2 = 64'd0; intf.ms_allowin = 1'b0;
        @(posedge clk); #1;
        intf.ds_to_es_valid = 1'b0;
        @(negedge clk) intf.flush = 1'b1;
        @(posedge clk); #1;
        intf.flush = 1'b0; intf.ms_allowin = 1'b1;
        checks++; if (intf.es_to_ms_valid !== 1'b0) $display("FAIL flush_done got v%b want 0", intf.es_to_ms_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        int          seen = 0;
        logic [63:0] res;
        logic [4:0]  rdo;
        int          lat;
        @(negedge clk);
        intf.ds_to_es_valid = 1'b1;
        intf.ds_op = 3'd1; intf.ds_src1 = 64'd123; intf.ds_src2 = 64'd456; intf.ds_rd = 5'd21;
        @(posedge clk); #1;
        intf.ds_to_es_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (intf.es_busy !== 1'b0 || intf.es_to_ms_valid !== 1'b0 || intf.es_result !== 64'd0 || intf.es_rd !== 5'd0)
            $display("FAIL reset_mid got busy%b v%b %h rd%0d want all 0", intf.es_busy, intf.es_to_ms_valid, intf.es_result, intf.es_rd);
        else passed++;
        @(negedge clk) rst = 1'b1;
        repeat (80) begin @(posedge clk); #1; if (intf.es_to_ms_valid) seen++; end
        checks++; if (seen !== 0) $display("FAIL reset_no_result got %0d valid cycles want 0", seen); else passed++;
        do_op(3'd7, 64'd100, 64'd7, 5'd2, res, rdo, lat);
        checks++; if (res !== 64'd2 || lat !== 65) $display("FAIL after_reset got %h lat%0d want 2 lat65", res, lat); else passed++;
    endtask

`ifdef YSYX_22040759_MDU_WORD_EN
    task automatic test_word();
        logic [63:0] res;
        logic [4:0]  rdo;
        int          lat;
        intf.ds_word = 1'b1;
        do_op(3'd0, 64'h7FFF_FFFF, 64'd2, 5'd5, res, rdo, lat);
        intf.ds_word = 1'b0;
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 33)
            $display("FAIL mulw got %h lat%0d want %h lat33", res, lat, 64'hFFFF_FFFF_FFFF_FFFE);
        else passed++;
    endtask
`endif

    initial begin
        intf.ds_to_es_valid = 1'b0;
        intf.ds_op     = 3'd0;
        intf.ds_word   = 1'b0;
        intf.ds_rd     = 5'd0;
        intf.ds_src1   = '0;
        intf.ds_src2   = '0;
        intf.fwd_sel_a = '0;
        intf.fwd_sel_b = '0;
        intf.fwd_data  = '0;
        intf.flush     = 1'b0;
        intf.ms_allowin = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_forwarding();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef YSYX_22040759_MDU_WORD_EN
        test_word();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
